// File: rtl/iomem_bellek_yonlendirici.sv
// iomem request router: RAM window with emulated latency, 64-bit timer, error path.
// A single FSM serialises accesses and completes each with a one-cycle ready pulse.
module iomem_bellek_yonlendirici #(
    parameter logic [31:0] RAM_BASE_ADDR   = 32'h4000_0000,
    parameter logic [31:0] RAM_MASK_ADDR   = 32'h00ff_ffff,
    parameter int unsigned RAM_DELAY       = 16,
    parameter logic [31:0] TIMER_BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ERR_RDATA       = 32'hDEAD_BEEF,
    parameter int unsigned RAM_ADDR_W      = 18
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  iomem_valid_i,
    output logic                  iomem_ready_o,
    input  logic [3:0]            iomem_wstrb_i,
    input  logic [31:0]           iomem_addr_i,
    input  logic [31:0]           iomem_wdata_i,
    output logic [31:0]           iomem_rdata_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic [3:0]            ram_wstrb_o,
    output logic                  ram_rd_en_o,
    input  logic [31:0]           ram_rdata_i,
    output logic                  bus_err_o,
    output logic [63:0]           timer_o
);

    typedef enum logic [2:0] {
        IDLE,
        RAM_WAIT,
        TMR_RESP,
        ERR_RESP,
        GAP
    } state_e;

    localparam logic [31:0] TIMER_MASK = 32'h0000_000f;
    localparam logic [7:0]  DELAY_LOAD = 8'(RAM_DELAY - 1);

    state_e                state_q;
    state_e                state_d;
    logic [7:0]            cnt_q;
    logic [RAM_ADDR_W-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            ram_wstrb_q;
    logic                  rd_en_q;
    logic                  rd_cap_q;
    logic [31:0]           rdata_q;
    logic [63:0]           timer_q;
    logic                  en_q;
    logic [31:0]           shadow_q;

    logic                  ram_hit;
    logic                  tmr_hit;
    logic                  accept;
    logic                  ram_acc;
    logic                  tmr_acc;
    logic                  err_acc;
    logic                  is_wr;
    logic [1:0]            tmr_off;
    logic [31:0]           tmr_rdata;
    logic [31:0]           tmr_wlo;
    logic [31:0]           tmr_whi;

    assign ram_hit = (iomem_addr_i & ~RAM_MASK_ADDR) == RAM_BASE_ADDR;
    assign tmr_hit = (iomem_addr_i & ~TIMER_MASK) == TIMER_BASE_ADDR;
    assign accept  = (state_q == IDLE) && iomem_valid_i;
    assign ram_acc = accept && ram_hit;
    assign tmr_acc = accept && !ram_hit && tmr_hit;
    assign err_acc = accept && !ram_hit && !tmr_hit;
    assign is_wr   = |iomem_wstrb_i;
    assign tmr_off = iomem_addr_i[3:2];

    // Timer register read mux and byte-lane merge for timer writes
    always_comb begin
        tmr_rdata = '0;
        tmr_wlo   = timer_q[31:0];
        tmr_whi   = timer_q[63:32];
        case (tmr_off)
            2'd0:    tmr_rdata = timer_q[31:0];
            2'd1:    tmr_rdata = shadow_q;
            2'd2:    tmr_rdata = {31'b0, en_q};
            default: tmr_rdata = '0;
        endcase
        for (int b = 0; b < 4; b++) begin
            if (iomem_wstrb_i[b]) begin
                tmr_wlo[8*b +: 8] = iomem_wdata_i[8*b +: 8];
                tmr_whi[8*b +: 8] = iomem_wdata_i[8*b +: 8];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: RAM decode has priority over the timer window
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (iomem_valid_i) begin
                    if (ram_hit) begin
                        state_d = RAM_WAIT;
                    end else if (tmr_hit) begin
                        state_d = TMR_RESP;
                    end else begin
                        state_d = ERR_RESP;
                    end
                end
            end
            RAM_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = GAP;
                end
            end
            TMR_RESP: state_d = GAP;
            ERR_RESP: state_d = GAP;
            GAP:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs: completion pulse and error flag
    always_comb begin
        iomem_ready_o = 1'b0;
        bus_err_o     = 1'b0;
        case (state_q)
            RAM_WAIT: iomem_ready_o = (cnt_q == 8'd0);
            TMR_RESP: iomem_ready_o = 1'b1;
            ERR_RESP: begin
                iomem_ready_o = 1'b1;
                bus_err_o     = 1'b1;
            end
            default: iomem_ready_o = 1'b0;
        endcase
    end

    // Request latch, RAM strobes, latency counter and read data register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ram_wstrb_q <= '0;
            rd_en_q     <= 1'b0;
            rd_cap_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ram_wstrb_q <= ram_acc ? iomem_wstrb_i : 4'b0;
            rd_en_q     <= ram_acc && !is_wr;
            rd_cap_q    <= rd_en_q;
            if (ram_acc) begin
                addr_q  <= iomem_addr_i[RAM_ADDR_W+1:2];
                wdata_q <= iomem_wdata_i;
                cnt_q   <= DELAY_LOAD;
            end else if (state_q == RAM_WAIT && cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end
            if (rd_cap_q) begin
                rdata_q <= ram_rdata_i;
            end else if (tmr_acc && !is_wr) begin
                rdata_q <= tmr_rdata;
            end else if (err_acc) begin
                rdata_q <= ERR_RDATA;
            end
        end
    end

    // Free-running timer; a word write replaces that cycle's increment
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q  <= '0;
            en_q     <= 1'b1;
            shadow_q <= '0;
        end else begin
            if (tmr_acc && is_wr && tmr_off == 2'd0) begin
                timer_q[31:0] <= tmr_wlo;
            end else if (tmr_acc && is_wr && tmr_off == 2'd1) begin
                timer_q[63:32] <= tmr_whi;
            end else if (en_q) begin
                timer_q <= timer_q + 64'd1;
            end
            if (tmr_acc && is_wr && tmr_off == 2'd2 && iomem_wstrb_i[0]) begin
                en_q <= iomem_wdata_i[0];
            end
            if (tmr_acc && !is_wr && tmr_off == 2'd0) begin
                shadow_q <= timer_q[63:32];
            end
        end
    end

    // RAM read data is forwarded in its arrival cycle so short delays still see it
    assign iomem_rdata_o = rd_cap_q ? ram_rdata_i : rdata_q;
    assign ram_addr_o    = addr_q;
    assign ram_wdata_o   = wdata_q;
    assign ram_wstrb_o   = ram_wstrb_q;
    assign ram_rd_en_o   = rd_en_q;
    assign timer_o       = timer_q;

endmodule
